// File: rtl/crush_pkg.sv
// crush_pkg: shared types and constants for the bit-crusher sequencer.
// FSM state encoding, CV thresholds, level-to-mask helper, dither LFSR setup.
package crush_pkg;

   localparam int LEVEL_W   = 4;
   localparam int LEVEL_MAX = 10;
   localparam int THR_STEP  = 2000;

   // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEVEL,
      ST_CH1,
      ST_CH2,
      ST_CH3,
      ST_COMMIT
   } state_t;

   // Threshold for level k: 2000*k counts
   function automatic int thr(input int k);
      return THR_STEP * k;
   endfunction

   // Keep the top lvl+2 bits of a w-bit sample; full level keeps every bit.
   // Result is right-aligned in 32 bits, so w must not exceed 32.
   function automatic logic [31:0] level_to_mask(input logic [LEVEL_W-1:0] lvl, input int w);
      logic [31:0] m;
      int keep;
      m    = '0;
      keep = (int'(lvl) >= LEVEL_MAX) ? w : int'(lvl) + 2;
      for (int i = 0; i < 32; i++) begin
         if (i < w && i >= w - keep) begin
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/crush_level.sv
// crush_level: CV hysteresis comparator with slew counter and level register.
// Evaluates once every SLEW_SAMPLES enables, stepping at most one level.
module crush_level
   import crush_pkg::*;
#(
   parameter int W            = 16,
   parameter int HYST         = 400,
   parameter int SLEW_SAMPLES = 8
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic signed [W-1:0]  cv,
   output logic [LEVEL_W-1:0]   level
);

   localparam int CNT_W = (SLEW_SAMPLES > 1) ? $clog2(SLEW_SAMPLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLEW_SAMPLES - 1);

   logic [CNT_W-1:0]   cnt_reg;
   logic [LEVEL_W-1:0] level_reg;
   logic [LEVEL_W-1:0] level_next;
   int                 cv_i;
   int                 lvl_i;

   // Candidate level: up takes priority, down only if up not taken
   always_comb begin
      cv_i       = int'(cv);
      lvl_i      = int'(level_reg);
      level_next = level_reg;
      if (lvl_i < LEVEL_MAX && cv_i > thr(lvl_i + 1) + HYST) begin
         level_next = level_reg + 1'b1;
      end else if (lvl_i > 0 && cv_i <= thr(lvl_i) - HYST) begin
         level_next = level_reg - 1'b1;
      end
   end

   // Slew counter gates when the candidate level is committed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg   <= '0;
         level_reg <= LEVEL_W'(LEVEL_MAX);
      end else if (en) begin
         if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            level_reg <= level_next;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign level = level_reg;

endmodule

// File: rtl/crush_sched.sv
// crush_sched: bit-crusher sequencer. One shared mask unit serves channels
// 1..3 per sample strobe; channel 0 is the CV that sets the level.
// Optional dither: define CRUSH_DITHER_EN to add LFSR noise below the mask.
module crush_sched
   import crush_pkg::*;
#(
   parameter int W            = 16,
   parameter int HYST         = 400,
   parameter int SLEW_SAMPLES = 8
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_clk,
   input  logic signed [W-1:0]  sample_in0,
   input  logic signed [W-1:0]  sample_in1,
   input  logic signed [W-1:0]  sample_in2,
   input  logic signed [W-1:0]  sample_in3,
   output logic signed [W-1:0]  sample_out0,
   output logic signed [W-1:0]  sample_out1,
   output logic signed [W-1:0]  sample_out2,
   output logic signed [W-1:0]  sample_out3,
   output logic [LEVEL_W-1:0]   level,
   output logic                 busy,
   output logic                 overrun
);

   state_t              state_reg;
   state_t              state_next;
   logic [2:0]          sync_reg;
   logic                strobe;
   logic                accept;
   logic                level_en;
   logic                overrun_reg;
   logic signed [W-1:0] snap_reg [0:3];
   logic signed [W-1:0] hold_reg [1:3];
   logic signed [W-1:0] out_reg  [0:3];
   logic signed [W-1:0] sel;
   logic [W-1:0]        mask;
   logic [W-1:0]        crushed;

   // Two-flop synchroniser plus one delay flop for rising-edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[1:0], sample_clk};
      end
   end

   assign strobe = sync_reg[1] & ~sync_reg[2];

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state and per-state controls; a strobe is only accepted in IDLE
   always_comb begin
      state_next = state_reg;
      busy       = 1'b1;
      accept     = 1'b0;
      level_en   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            busy = 1'b0;
            if (strobe) begin
               state_next = ST_LEVEL;
               accept     = 1'b1;
            end
         end
         ST_LEVEL: begin
            level_en   = 1'b1;
            state_next = ST_CH1;
         end
         ST_CH1:    state_next = ST_CH2;
         ST_CH2:    state_next = ST_CH3;
         ST_CH3:    state_next = ST_COMMIT;
         ST_COMMIT: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   crush_level #(
      .W            (W),
      .HYST         (HYST),
      .SLEW_SAMPLES (SLEW_SAMPLES)
   ) u_level (
      .clk   (clk),
      .rst   (rst),
      .en    (level_en),
      .cv    (snap_reg[0]),
      .level (level)
   );

   // Shared datapath input: the snapshot of the channel being processed
   always_comb begin
      sel = snap_reg[1];
      case (state_reg)
         ST_CH2:  sel = snap_reg[2];
         ST_CH3:  sel = snap_reg[3];
         default: sel = snap_reg[1];
      endcase
   end

   assign mask = W'(level_to_mask(level, W));

`ifdef CRUSH_DITHER_EN
   localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};

   logic [15:0] lfsr_reg;
   logic [W-1:0] noise;
   logic [W:0]   sum;

   // Dither LFSR advances once per channel slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_reg <= LFSR_SEED;
      end else if (state_reg == ST_CH1 || state_reg == ST_CH2 || state_reg == ST_CH3) begin
         lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
      end
   end

   // Noise sits only in the bits the mask discards, so it is never negative
   // and overflow can only be positive: clamp to the largest positive sample.
   assign noise = W'(lfsr_reg) & ~mask;
   assign sum   = {sel[W-1], sel} + {1'b0, noise};

   // Saturating add then truncate to the current level
   always_comb begin
      crushed = sum[W-1:0] & mask;
      if (sum[W] != sum[W-1]) begin
         crushed = POS_MAX & mask;
      end
   end
`else
   assign crushed = sel & mask;
`endif

   // Snapshot capture, channel holding registers, simultaneous output commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            snap_reg[i] <= '0;
            out_reg[i]  <= '0;
         end
         for (int i = 1; i < 4; i++) begin
            hold_reg[i] <= '0;
         end
      end else begin
         if (accept) begin
            snap_reg[0] <= sample_in0;
            snap_reg[1] <= sample_in1;
            snap_reg[2] <= sample_in2;
            snap_reg[3] <= sample_in3;
         end
         case (state_reg)
            ST_CH1: hold_reg[1] <= crushed;
            ST_CH2: hold_reg[2] <= crushed;
            ST_CH3: hold_reg[3] <= crushed;
            ST_COMMIT: begin
               out_reg[0] <= snap_reg[0];
               out_reg[1] <= hold_reg[1];
               out_reg[2] <= hold_reg[2];
               out_reg[3] <= hold_reg[3];
            end
            default: ;
         endcase
      end
   end

   // Sticky flag for strobes dropped while a sequence is running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_reg <= 1'b0;
      end else if (strobe && state_reg != ST_IDLE) begin
         overrun_reg <= 1'b1;
      end
   end

   assign overrun     = overrun_reg;
   assign sample_out0 = out_reg[0];
   assign sample_out1 = out_reg[1];
   assign sample_out2 = out_reg[2];
   assign sample_out3 = out_reg[3];

endmodule

// File: tb/tb_crush_sched.sv
// tb_crush_sched: directed checks of crush_sched. Instance A uses no slew,
// instance B uses an 8-strobe slew; both share the data inputs.
module tb_crush_sched;

   logic        clk;
   logic        rst;
   logic        sclk_a;
   logic        sclk_b;
   logic [15:0] in0, in1, in2, in3;
   logic [15:0] a_out0, a_out1, a_out2, a_out3;
   logic [15:0] b_out0, b_out1, b_out2, b_out3;
   logic [3:0]  a_level, b_level;
   logic        a_busy, b_busy, a_ovr, b_ovr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          in0;
      logic [15:0] in1;
      logic [3:0]  lvl;
      logic [15:0] out1;
      logic [15:0] out2;
      logic [15:0] out3;
   } vec_t;

   vec_t vecs [10];

   crush_sched #(.W(16), .HYST(400), .SLEW_SAMPLES(1)) dut_a (
      .clk         (clk),
      .rst         (rst),
      .sample_clk  (sclk_a),
      .sample_in0  (in0),
      .sample_in1  (in1),
      .sample_in2  (in2),
      .sample_in3  (in3),
      .sample_out0 (a_out0),
      .sample_out1 (a_out1),
      .sample_out2 (a_out2),
      .sample_out3 (a_out3),
      .level       (a_level),
      .busy        (a_busy),
      .overrun     (a_ovr)
   );

   crush_sched #(.W(16), .HYST(400), .SLEW_SAMPLES(8)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .sample_clk  (sclk_b),
      .sample_in0  (in0),
      .sample_in1  (in1),
      .sample_in2  (in2),
      .sample_in3  (in3),
      .sample_out0 (b_out0),
      .sample_out1 (b_out1),
      .sample_out2 (b_out2),
      .sample_out3 (b_out3),
      .level       (b_level),
      .busy        (b_busy),
      .overrun     (b_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // One full sample period on instance A (sel=0) or B (sel=1); ends on a negedge
   task automatic pulse(input bit sel);
      if (sel) sclk_b = 1'b1; else sclk_a = 1'b1;
      repeat (10) @(posedge clk);
      sclk_a = 1'b0;
      sclk_b = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
   endtask

   // Bounded wait for instance A to leave IDLE
   task automatic wait_busy_a(input string name);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = a_busy;
      end
      chk(name, seen, 1);
   endtask

   initial begin
      logic [15:0] exp0;

      vecs[0] = '{10400, 16'h1234, 4'd9, 16'h1220, 16'hFFE0, 16'h5A40};
      vecs[1] = '{10400, 16'h1234, 4'd8, 16'h1200, 16'hFFC0, 16'h5A40};
      vecs[2] = '{10400, 16'h1234, 4'd7, 16'h1200, 16'hFF80, 16'h5A00};
      vecs[3] = '{10400, 16'h1234, 4'd6, 16'h1200, 16'hFF00, 16'h5A00};
      vecs[4] = '{10400, 16'h1234, 4'd5, 16'h1200, 16'hFE00, 16'h5A00};
      vecs[5] = '{10400, 16'h1234, 4'd5, 16'h1200, 16'hFE00, 16'h5A00};
      vecs[6] = '{ 9900, 16'h1234, 4'd5, 16'h1200, 16'hFE00, 16'h5A00};
      vecs[7] = '{ 9500, 16'h1234, 4'd4, 16'h1000, 16'hFC00, 16'h5800};
      vecs[8] = '{10300, 16'h1234, 4'd4, 16'h1000, 16'hFC00, 16'h5800};
      vecs[9] = '{10500, 16'h1234, 4'd5, 16'h1200, 16'hFE00, 16'h5A00};

      rst    = 1'b1;
      sclk_a = 1'b0;
      sclk_b = 1'b0;
      in0 = '0; in1 = '0; in2 = 16'hFFFF; in3 = 16'h5A5A;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_level", a_level, 10);
      chk("rst_out1", a_out1, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_overrun", a_ovr, 0);
      chk("rst_level_b", b_level, 10);
      rst = 1'b0;
      @(negedge clk);

      // Hysteresis table, no slew
      for (int i = 0; i < 10; i++) begin
         in0 = 16'(vecs[i].in0);
         in1 = vecs[i].in1;
         pulse(1'b0);
         exp0 = 16'(vecs[i].in0);
         chk($sformatf("vec%0d_level", i), a_level, vecs[i].lvl);
         chk($sformatf("vec%0d_out0", i), a_out0, exp0);
`ifndef CRUSH_DITHER_EN
         chk($sformatf("vec%0d_out1", i), a_out1, vecs[i].out1);
         chk($sformatf("vec%0d_out2", i), a_out2, vecs[i].out2);
         chk($sformatf("vec%0d_out3", i), a_out3, vecs[i].out3);
`endif
         chk($sformatf("vec%0d_overrun", i), a_ovr, 0);
         chk($sformatf("vec%0d_busy", i), a_busy, 0);
      end

      // Overrun: second strobe lands while the sequence is running
      in0 = 16'd10500;
      in1 = 16'h0FFF;
      sclk_a = 1'b1;
      wait_busy_a("ovr_busy_seen");
      sclk_a = 1'b0;
      @(negedge clk);
      sclk_a = 1'b1;
      in1 = 16'h3FFF;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("ovr_flag", a_ovr, 1);
      chk("ovr_busy_done", a_busy, 0);
      chk("ovr_level", a_level, 5);
`ifndef CRUSH_DITHER_EN
      chk("ovr_out1_inflight", a_out1, 16'h0E00);
`endif
      sclk_a = 1'b0;
      repeat (6) @(negedge clk);
      pulse(1'b0);
      chk("ovr_sticky", a_ovr, 1);
`ifndef CRUSH_DITHER_EN
      chk("ovr_next_out1", a_out1, 16'h3E00);
`endif

      // Reset in the middle of a sequence
      in0 = 16'd10400;
      in1 = 16'h1234;
      sclk_a = 1'b1;
      wait_busy_a("rst_mid_busy_seen");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_out0", a_out0, 0);
      chk("rst_mid_out1", a_out1, 0);
      chk("rst_mid_level", a_level, 10);
      chk("rst_mid_busy", a_busy, 0);
      chk("rst_mid_overrun", a_ovr, 0);
      sclk_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pulse(1'b0);
      chk("post_rst_level", a_level, 9);
      chk("post_rst_out0", a_out0, 16'd10400);
`ifndef CRUSH_DITHER_EN
      chk("post_rst_out1", a_out1, 16'h1220);
`endif
      chk("post_rst_overrun", a_ovr, 0);

      // Slew-limited descent on instance B: one step per 8 strobes
      in0 = 16'hFF9C;  // -100
      in1 = 16'h7FFF;
      for (int k = 1; k <= 80; k++) begin
         pulse(1'b1);
         chk($sformatf("slew_k%0d_level", k), b_level, 10 - k / 8);
      end
      chk("slew_out0", b_out0, 16'hFF9C);
      chk("lvl0_out1_max", b_out1, 16'h4000);
      chk("slew_overrun", b_ovr, 0);
`ifndef CRUSH_DITHER_EN
      in1 = 16'hFFFF;
      pulse(1'b1);
      chk("lvl0_out1_neg1", b_out1, 16'hC000);
`endif

      // Full-scale positive input at level 0 never wraps negative
      in1 = 16'h7FFF;
      for (int k = 0; k < 64; k++) begin
         pulse(1'b1);
         chk($sformatf("sat_k%0d_out1", k), b_out1, 16'h4000);
      end
      chk("sat_level", b_level, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
